uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 177 +++++++++++++++++
 tb/tb_uart_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, LSB first. When UART_RX_PARITY_EN is defined the frame is 8E1,
// and an extra uart_rx_parity_err pulse output is added.
module uart_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_done,
  output logic       uart_rx_busy,
`ifdef UART_RX_PARITY_EN
  output logic       uart_rx_parity_err,
`endif
  output logic       uart_rx_frame_err
);

  localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam logic [15:0] BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);
  localparam logic [15:0] BAUD_MID     = 16'(BAUD_CNT_MAX / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e      state_q, state_d;
  logic        rxd_meta_q, rxd_s_q, rxd_d_q;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d;
  logic        perr_q, perr_d;
`endif

  logic       fall;
  logic       baud_wrap;
  logic       mid;
  logic [2:0] bit_idx;

  // Sync flops reset high so a line that idles high produces no spurious edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_d_q    <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_s_q    <= rxd_meta_q;
      rxd_d_q    <= rxd_s_q;
    end
  end

  assign fall      = rxd_d_q & ~rxd_s_q;
  assign baud_wrap = (baud_cnt_q == BAUD_LAST);
  assign mid       = (baud_cnt_q == BAUD_MID);
  assign bit_idx   = 3'(bit_cnt_q - 4'd1);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    perr_d     = 1'b0;
`endif

    if (state_q != IDLE) begin
      if (baud_wrap) begin
        baud_cnt_d = 16'd0;
        bit_cnt_d  = bit_cnt_q + 4'd1;
      end else begin
        baud_cnt_d = baud_cnt_q + 16'd1;
      end
    end

    case (state_q)
      IDLE: begin
        baud_cnt_d = 16'd0;
        if (fall) begin
          state_d   = START;
          bit_cnt_d = 4'd0;
        end
      end
      START: begin
        // A start bit that is already high again at mid-bit was a glitch.
        if (mid && rxd_s_q) state_d = IDLE;
        else if (baud_wrap) state_d = DATA;
      end
      DATA: begin
        if (mid) shift_d[bit_idx] = rxd_s_q;
        if (baud_wrap && bit_cnt_q == 4'd8) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid) par_d = rxd_s_q;
        if (baud_wrap) state_d = STOP;
      end
`endif
      STOP: begin
        // Leave at mid-stop so a start bit immediately following is not missed.
        if (mid) begin
          state_d = IDLE;
          if (!rxd_s_q) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (^{shift_q, par_q}) begin
            perr_d = 1'b1;
`endif
          end else begin
            done_d = 1'b1;
            data_d = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign uart_rx_data      = data_q;
  assign uart_rx_done      = done_q;
  assign uart_rx_busy      = busy_q;
  assign uart_rx_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign uart_rx_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames push expected events, a monitor pops on every pulse.
module tb_uart_rx;

  localparam int BIT    = 434;
`ifdef UART_RX_PARITY_EN
  localparam int LAT    = 10 * BIT + BIT / 2 + 3;
`else
  localparam int LAT    = 9 * BIT + BIT / 2 + 3;
`endif
  localparam int K_DONE = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    longint     start;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       uart_rxd;
  logic [7:0] uart_rx_data;
  logic       uart_rx_done;
  logic       uart_rx_busy;
  logic       uart_rx_frame_err;
  logic       perr;

  exp_t       sb[$];
  longint     cyc;
  int         n_vec;
  int         n_err;
  logic [7:0] held;

  uart_rx #(.CLK_FREQ(50000000), .UART_BPS(115200)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .uart_rxd          (uart_rxd),
    .uart_rx_data      (uart_rx_data),
    .uart_rx_done      (uart_rx_done),
    .uart_rx_busy      (uart_rx_busy),
`ifdef UART_RX_PARITY_EN
    .uart_rx_parity_err(perr),
`endif
    .uart_rx_frame_err (uart_rx_frame_err)
  );

`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (uart_rx_done || uart_rx_frame_err || perr)) begin
      int   kind;
      exp_t e;
      check("pulse_exclusive", 32'(uart_rx_done + uart_rx_frame_err + perr), 32'd1);
      kind = uart_rx_frame_err ? K_FERR : (perr ? K_PERR : K_DONE);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: got kind %0d expected none at cycle %0d", kind, cyc);
      end else begin
        e = sb.pop_front();
        check("event_kind", 32'(kind), 32'(e.kind));
        check("event_data", 32'(uart_rx_data), 32'(e.data));
        n_vec++;
        if (cyc - e.start < LAT - 1 || cyc - e.start > LAT + 2) begin
          n_err++;
          $display("FAIL latency: got %0d expected %0d..%0d", cyc - e.start, LAT - 1, LAT + 2);
        end
      end
    end
  end

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    repeat (BIT) @(negedge clk);
  endtask

  // Sends one frame and queues what the receiver should report for it.
  task automatic frame(input logic [7:0] b, input logic stop, input logic par_flip);
    exp_t e;
    e.start = cyc;
    if (!stop) begin
      e.kind = K_FERR;
      e.data = held;
`ifdef UART_RX_PARITY_EN
    end else if (par_flip) begin
      e.kind = K_PERR;
      e.data = held;
`endif
    end else begin
      e.kind = K_DONE;
      e.data = b;
      held   = b;
    end
    sb.push_back(e);
    drive_bit(1'b0);
    check("busy_in_frame", 32'(uart_rx_busy), 32'd1);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop);
    check("busy_after_frame", 32'(uart_rx_busy), 32'd0);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    cyc      = 0;
    held     = 8'h00;
    uart_rxd = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(uart_rx_data), 32'h00);
    check("rst_done", 32'(uart_rx_done), 32'd0);
    check("rst_busy", 32'(uart_rx_busy), 32'd0);
    check("rst_ferr", 32'(uart_rx_frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (BIT) @(negedge clk);

    frame(8'h55, 1'b1, 1'b0);
    check("data_55", 32'(uart_rx_data), 32'h55);
    repeat (BIT) @(negedge clk);

    // 100-clock glitch: false start, rejected at mid start bit
    uart_rxd = 1'b0;
    repeat (100) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (50) @(negedge clk);
    check("glitch_busy_hi", 32'(uart_rx_busy), 32'd1);
    repeat (110) @(negedge clk);
    check("glitch_busy_lo", 32'(uart_rx_busy), 32'd0);
    check("glitch_data", 32'(uart_rx_data), 32'h55);
    repeat (BIT) @(negedge clk);

    frame(8'hA3, 1'b0, 1'b0);
    check("ferr_data_kept", 32'(uart_rx_data), 32'h55);
    uart_rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    frame(8'h0F, 1'b1, 1'b0);
    check("data_0F", 32'(uart_rx_data), 32'h0F);

    // back-to-back, zero idle between stop and next start
    frame(8'hA3, 1'b1, 1'b0);
    frame(8'h0F, 1'b1, 1'b0);
    repeat (BIT) @(negedge clk);

    // reset during data bit 4 of 0xFF
    uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3 * BIT + BIT / 2) @(negedge clk);
    check("pre_rst_busy", 32'(uart_rx_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_data", 32'(uart_rx_data), 32'h00);
    check("midrst_busy", 32'(uart_rx_busy), 32'd0);
    check("midrst_done", 32'(uart_rx_done), 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    held  = 8'h00;
    repeat (6 * BIT) @(negedge clk);
    check("post_rst_busy", 32'(uart_rx_busy), 32'd0);
    frame(8'h3C, 1'b1, 1'b0);
    check("data_3C", 32'(uart_rx_data), 32'h3C);
    repeat (BIT) @(negedge clk);

    // break: line held low yields exactly one frame error
    frame(8'h00, 1'b0, 1'b0);
    repeat (20 * BIT) @(negedge clk);
    check("break_busy", 32'(uart_rx_busy), 32'd0);
    check("break_data", 32'(uart_rx_data), 32'h3C);
    uart_rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    frame(8'h81, 1'b1, 1'b0);
    check("par_ok_data", 32'(uart_rx_data), 32'h81);
    frame(8'h81, 1'b1, 1'b1);
    check("par_err_data", 32'(uart_rx_data), 32'h81);
    repeat (BIT) @(negedge clk);
`endif

    for (int i = 0; i < 20 * BIT && sb.size() != 0; i++) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
